// File: rtl/monitor8_pkg.sv
// monitor8_pkg
//   Shared constants and types for the monitor8 report collector.
//   N_LTL properties, each with REPORTS_PER_LTL report bits, give the
//   N_REPORTS-wide report vector sampled from the automata stage.
//   report_entry_t is the FIFO entry layout at the default timestamp width.
//   ltl_hits() folds the report vector down to one "any report" bit per LTL.
package monitor8_pkg;

    localparam int N_LTL           = 9;
    localparam int REPORTS_PER_LTL = 4;
    localparam int N_REPORTS       = N_LTL * REPORTS_PER_LTL;
    localparam int TS_W_DEFAULT    = 32;

    typedef struct packed {
        logic [TS_W_DEFAULT-1:0] ts;
        logic [N_REPORTS-1:0]    reports;
    } report_entry_t;

    // Bit p of the result is the OR of reports[4p+3:4p].
    function automatic logic [N_LTL-1:0] ltl_hits(input logic [N_REPORTS-1:0] r);
        logic [N_LTL-1:0] hits;
        hits = '0;
        for (int p = 0; p < N_LTL; p++) begin
            hits[p] = |r[p*REPORTS_PER_LTL +: REPORTS_PER_LTL];
        end
        return hits;
    endfunction

endpackage

// File: rtl/monitor8_report_fifo.sv
// monitor8_report_fifo
//   Generic synchronous FIFO, DEPTH entries of WIDTH bits.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     flush        synchronous empty (wins over push/pop)
//     push, din    write din at the tail
//     pop          advance the head
//     dout         head entry (zero while empty)
//     full, empty  occupancy flags
//     level        occupancy, 0..DEPTH
//   The caller only pushes when !full or popping in the same cycle, and only
//   pops when !empty. Head is read straight from storage registers: a write
//   never appears on dout in the cycle it is pushed.
module monitor8_report_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [WIDTH-1:0] din,
    input  logic          pop,
    output logic [WIDTH-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Pointers carry an extra MSB so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/monitor8_report_collector.sv
// monitor8_report_collector
//   Samples the 36 automaton report bits each run cycle; every cycle with at
//   least one report becomes a {timestamp, reports} FIFO entry drained over a
//   valid/ready port. Also keeps per-LTL sticky violation flags and a
//   saturating count of entries dropped on FIFO overflow.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     run               sample enable / timestamp advance
//     clear             synchronous clear of ts, FIFO, flags, counters
//     reports           report vector, bit 4p+k = LTL p report k
//     out_valid/ready   head handshake: an entry transfers on a cycle where
//                       both are high; out_ts/out_reports hold while
//                       out_valid=1 and out_ready=0
//     out_ts, out_reports  head entry
//     sticky_viol       per-LTL OR of reports since reset/clear
//     overflow          sticky, at least one entry dropped
//     drop_count        dropped entries, saturating
//     fifo_level        occupancy
module monitor8_report_collector
    import monitor8_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   clear,
    input  logic [N_REPORTS-1:0]   reports,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [N_REPORTS-1:0]   out_reports,
    output logic [N_LTL-1:0]       sticky_viol,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int EW = TS_W + N_REPORTS;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [N_LTL-1:0]  sticky_q, sticky_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic          sample;
    logic          push;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_din;
    logic [EW-1:0] fifo_dout;

    // clear suppresses both sides of the FIFO in its cycle.
    assign sample   = run && (|reports);
    assign pop      = out_valid && out_ready && !clear;
    assign push     = sample && !clear && (!fifo_full || pop);
    assign drop     = sample && !clear && fifo_full && !pop;
    assign fifo_din = {ts_q, reports};

    always_comb begin
        ts_d       = ts_q;
        sticky_d   = sticky_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            ts_d       = '0;
            sticky_d   = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (run) begin
            ts_d     = ts_q + TS_W'(1);
            // Dropped entries still mark their properties.
            sticky_d = sticky_q | ltl_hits(reports);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != {DROP_W{1'b1}}) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    monitor8_report_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (clear),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out_valid               = !fifo_empty;
    assign {out_ts, out_reports}   = fifo_dout;
    assign sticky_viol             = sticky_q;
    assign overflow                = overflow_q;
    assign drop_count              = drop_q;

endmodule

// File: tb/tb_monitor8_report_collector.sv
module tb_monitor8_report_collector;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        run;
    logic        clear;
    logic [35:0] reports;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ts;
    logic [35:0] out_reports;
    logic [8:0]  sticky_viol;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    monitor8_report_collector #(
        .DEPTH  (DEPTH),
        .TS_W   (32),
        .DROP_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .reports     (reports),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ts      (out_ts),
        .out_reports (out_reports),
        .sticky_viol (sticky_viol),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .fifo_level  (fifo_level)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int tests = 0;
    int fails = 0;

    logic [67:0] exp_q[$];

    // cur_* : state the DUT should hold now; nxt_* : after the coming edge
    int          cur_level, nxt_level;
    logic [31:0] cur_ts, nxt_ts;
    logic [8:0]  cur_sticky, nxt_sticky;
    logic        cur_ovf, nxt_ovf;
    int          cur_drops, nxt_drops;

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_level = 0;  nxt_level = 0;
        cur_ts = '0;    nxt_ts = '0;
        cur_sticky = '0; nxt_sticky = '0;
        cur_ovf = 1'b0; nxt_ovf = 1'b0;
        cur_drops = 0;  nxt_drops = 0;
    endtask

    // ---------------- driver ----------------
    // One call = one clock cycle of stimulus; model predicts the next edge.
    task automatic step(input logic r, input logic c, input logic rdy, input logic [35:0] rep);
        bit pop_m;
        @(posedge clk);
        #1;
        cur_level = nxt_level; cur_ts = nxt_ts; cur_sticky = nxt_sticky;
        cur_ovf = nxt_ovf; cur_drops = nxt_drops;
        run = r; clear = c; out_ready = rdy; reports = rep;
        if (c) begin
            exp_q.delete();
            nxt_level = 0; nxt_ts = '0; nxt_sticky = '0; nxt_ovf = 1'b0; nxt_drops = 0;
        end else begin
            pop_m = (cur_level > 0) && rdy;
            if (r) begin
                for (int p = 0; p < 9; p++) begin
                    if (rep[4*p +: 4] != 4'h0) nxt_sticky[p] = 1'b1;
                end
                if (rep != '0) begin
                    if (cur_level < DEPTH || pop_m) begin
                        exp_q.push_back({cur_ts, rep});
                        nxt_level = nxt_level + 1;
                    end else begin
                        nxt_ovf = 1'b1;
                        nxt_drops = nxt_drops + 1;
                    end
                end
                nxt_ts = cur_ts + 32'd1;
            end
            if (pop_m) nxt_level = nxt_level - 1;
        end
    endtask

    function automatic logic [35:0] rand_rep();
        logic [35:0] v;
        v[35:32] = 4'($urandom_range(15, 0));
        v[31:0]  = $urandom();
        if (v == '0) v = 36'h1;
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("level", 68'(fifo_level), 68'(cur_level));
            chk("out_valid", 68'(out_valid), 68'(cur_level != 0));
            chk("sticky_viol", 68'(sticky_viol), 68'(cur_sticky));
            chk("overflow", 68'(overflow), 68'(cur_ovf));
            chk("drop_count", 68'(drop_count), 68'(sat16(cur_drops)));
            if (!clear && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("head_unexpected", {out_ts, out_reports}, 68'h0);
                end else begin
                    chk("head", {out_ts, out_reports}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; run = 1'b0; clear = 1'b0; out_ready = 1'b0; reports = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk("rst_out_valid", 68'(out_valid), 68'h0);
        chk("rst_out_ts", 68'(out_ts), 68'h0);
        chk("rst_out_reports", 68'(out_reports), 68'h0);
        chk("rst_fifo_level", 68'(fifo_level), 68'h0);

        // Ten quiet cycles, then a single report at ts=10
        repeat (10) step(1'b1, 1'b0, 1'b0, 36'h0);
        chk("quiet_valid", 68'(out_valid), 68'h0);
        step(1'b1, 1'b0, 1'b0, 36'h1);
        step(1'b1, 1'b0, 1'b0, 36'h0);
        chk("first_valid", 68'(out_valid), 68'h1);
        chk("first_ts", 68'(out_ts), 68'd10);
        chk("first_reports", 68'(out_reports), 68'h1);
        chk("first_sticky", 68'(sticky_viol), 68'h001);
        step(1'b0, 1'b0, 1'b1, 36'h0);

        // Overfill with out_ready low: 17 samples into 16 entries
        repeat (17) step(1'b1, 1'b0, 1'b0, rand_rep());
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("full_level", 68'(fifo_level), 68'd16);
        chk("full_overflow", 68'(overflow), 68'h1);
        chk("full_drop", 68'(drop_count), 68'd1);

        // Full + sample + pop: no drop, level unchanged
        step(1'b1, 1'b0, 1'b1, 36'hF_0000_0000);
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("fullpop_level", 68'(fifo_level), 68'd16);
        chk("fullpop_drop", 68'(drop_count), 68'd1);

        // Drain in order
        repeat (16) step(1'b0, 1'b0, 1'b1, 36'h0);
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("drained_level", 68'(fifo_level), 68'd0);

        // run toggling with reports held nonzero
        for (int i = 0; i < 12; i++) step(1'(i % 2), 1'b0, 1'b1, 36'h8_0000_0010);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3, 0) != 0,
                 $urandom_range(127, 0) == 0,
                 $urandom_range(2, 0) != 0,
                 ($urandom_range(1, 0) != 0) ? rand_rep() : 36'h0);
        end

        // Drop counter saturation, then clear
        step(1'b0, 1'b1, 1'b0, 36'h0);
        repeat (DEPTH + 65541) step(1'b1, 1'b0, 1'b0, 36'h0_0000_0100);
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("sat_drop", 68'(drop_count), 68'hFFFF);
        step(1'b0, 1'b1, 1'b0, 36'h0);
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("clr_valid", 68'(out_valid), 68'h0);
        chk("clr_drop", 68'(drop_count), 68'h0);
        chk("clr_overflow", 68'(overflow), 68'h0);
        chk("clr_sticky", 68'(sticky_viol), 68'h0);

        // Asynchronous reset with five entries queued
        repeat (5) step(1'b1, 1'b0, 1'b0, rand_rep());
        step(1'b0, 1'b0, 1'b0, 36'h0);
        chk("pre_rst_level", 68'(fifo_level), 68'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 68'(out_valid), 68'h0);
        chk("async_rst_level", 68'(fifo_level), 68'h0);
        model_reset();
        run = 1'b0; clear = 1'b0; out_ready = 1'b0; reports = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Post-reset traffic
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, $urandom_range(1, 0) != 0, rand_rep());
        repeat (20) step(1'b0, 1'b0, 1'b1, 36'h0);

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/monitor8_report_collector.md
# monitor8_report_collector

Downstream consumer of the cluster-1 stage-0 automata stage. Each cycle it samples the 36 automaton report bits (9 LTL properties × 4 report states). Any cycle with at least one asserted report is stored as a timestamped entry in an internal FIFO, and entries drain over a valid/ready port to the monitor readout path. It also keeps per-property sticky violation flags and a saturating drop counter for FIFO overflow.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- TS_W, 32, timestamp width
- DROP_W, 16, dropped-entry counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low; clears all state
- run  in  1  sample enable, same signal that drives the automata stage
- clear  in  1  synchronous clear of timestamp, FIFO, sticky flags, drop counter
- reports  in  36  report bits; bit 4*p+k = ltl{p}c1_w_out_{4,6,9,11}[k], p=0..8, k=0..3
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_ts  out  TS_W  timestamp of head entry
- out_reports  out  36  report vector of head entry
- sticky_viol  out  9  per-LTL OR of all reports seen since reset/clear
- overflow  out  1  sticky: at least one entry dropped
- drop_count  out  DROP_W  entries dropped, saturating at all-ones
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Timestamp counter ts: +1 each cycle run=1; wraps modulo 2^TS_W; holds when run=0.
- Sample event: run=1 and |reports. Entry = {ts (pre-increment value), reports}.
- Push: on a sample event, when FIFO is not full or a pop occurs in the same cycle.
- Drop: on a sample event with FIFO full and no pop. Entry discarded, overflow←1, drop_count+1 (saturating).
- Pop: out_valid && out_ready. Head advances; no fall-through, head is registered storage.
- sticky_viol[p] |= |reports[4p+3:4p] on every cycle with run=1, independent of FIFO state (dropped entries still set it).
- clear=1: ts←0, FIFO emptied, sticky_viol←0, overflow←0, drop_count←0. A sample or pop in the same cycle is ignored. clear overrides run.
- run=0: no sample, no ts change. Pops continue.
- States are implicit (FIFO EMPTY / PARTIAL / FULL by level); no other FSM.

## Timing
- Reset values: out_valid=0, out_ts=0, out_reports=0, sticky_viol=0, overflow=0, drop_count=0, fifo_level=0, internal ts=0.
- Latency: sample at edge N appears on out_valid after edge N (visible in cycle N+1) when FIFO was empty.
- sticky_viol, overflow, drop_count update at the same edge as the sample.
- out_ts/out_reports stable while out_valid=1 and out_ready=0.
- Full plus sample plus pop in the same cycle: push accepted, level unchanged, no drop.
- Empty plus pop: cannot occur (out_valid=0).
- Reset asserted mid-operation: all state cleared asynchronously; FIFO contents lost.
- Pointer wrap: read/write pointers carry one extra MSB; full = MSBs differ and LSBs equal.

## Structure
- monitor8_pkg: N_LTL=9, REPORTS_PER_LTL=4, N_REPORTS=36, typedef report_entry_t {ts, reports}.
- Sub-module monitor8_report_fifo: generic sync FIFO (DEPTH, WIDTH), async active-low reset, push/pop/full/empty/level. Collector holds ts counter, drop/sticky logic, entry packing.

## Test plan
- Reset, run=1, reports=0 for 10 cycles -> out_valid=0, sticky_viol=0; then reports=36'h1 at ts=10 -> next cycle out_valid=1, out_ts=10, out_reports=36'h1, sticky_viol=9'h001.
- out_ready=0, 17 consecutive sample events (DEPTH=16) -> fifo_level=16, overflow=1, drop_count=1; drain yields ts values in order, 16 entries.
- FIFO full, sample with out_ready=1 same cycle -> no drop, level stays 16, new entry at tail.
- run toggled 0/1 with reports held nonzero -> entries only on run=1 cycles, ts contiguous (no gaps for run=0 cycles).
- 2^16+5 drops -> drop_count=16'hFFFF; clear -> all counters/flags 0, out_valid=0 next cycle.
- Reset deasserted→asserted with 5 entries queued -> out_valid=0 and fifo_level=0 immediately, without waiting for a clock edge.
